serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock. It is built around a single full-subtractor cell and a registered borrow, and is the subtraction counterpart to the team's adder blocks. It trades latency for area in the arithmetic datapath. A start/busy/done handshake lets a controller launch operations and collect results.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request a new operation; sampled only in IDLE
a  input  WIDTH  minuend, captured on the accepting edge
b  input  WIDTH  subtrahend, captured on the accepting edge
bin  input  1  borrow-in, captured on the accepting edge
busy  output  1  high while in SHIFT
done  output  1  single-cycle pulse when the result is valid
diff  output  WIDTH  difference (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)

Behaviour:
Interface:
- One clock: clk.
- Reset rst is asynchronous and active-high.
- While rst is high: state=IDLE, busy=0, done=0, diff=0, bout=0, and internal shift registers, borrow and counter are cleared.

States:
- IDLE: start=1 at a rising edge loads a->A_sh, b->B_sh, bin->br, count=0, and moves to SHIFT. Otherwise the state holds.
- SHIFT, evaluated on each edge:
  - d = A_sh[0]^B_sh[0]^br
  - br <= (~A_sh[0]&B_sh[0]) | (~(A_sh[0]^B_sh[0])&br)
  - D_sh <= {d, D_sh[WIDTH-1:1]}
  - A_sh and B_sh shift right by one
  - count <= count+1
  - When count==WIDTH-1, also: diff <= {d, D_sh[WIDTH-1:1]}, bout <= the new borrow, done <= 1, state <= DONE.
- DONE: lasts exactly one cycle, with done=1. Next edge: done <= 0, state <= IDLE.

Timing:
- Latency: the accepting edge is edge 0. Shifts occur on edges 1..WIDTH. done is high from edge WIDTH to edge WIDTH+1.
- Minimum spacing between accepted starts is WIDTH+2 edges.

Signal rules:
- busy = (state==SHIFT), decoded from registered state.
- diff and bout update only on the final SHIFT edge. They hold their value through DONE and IDLE until the next completion, and do not change at start acceptance.
- start while in SHIFT or DONE is ignored: no queueing, no effect on the operation in progress.
- Inputs a, b and bin are don't-care except on the accepting edge.

Boundary conditions:
- Wrap-around: results are modulo 2^WIDTH. Underflow is reported only via bout.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1.
- Reset asserted mid-SHIFT aborts immediately and clears diff and bout to 0. No done pulse is produced. After release, the block sits in IDLE.
- rst release coincident with start=1: start is sampled at the first edge after deassertion and accepted normally.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default WIDTH constant
- Sub-module full_subtractor (combinational):
  - inputs x, y, bi; outputs d, bo
  - d = x^y^bi; bo = (~x&y)|(~(x^y)&bi)
  - Instantiated once on the LSBs of the shift registers.

Test Plan:
- Basic: a=100, b=37, bin=0, start one cycle -> busy high for 8 cycles, done pulses one cycle at edge 8, diff=63, bout=0.
- Underflow: a=5, b=9, bin=0 -> diff=8'hFC (252), bout=1.
- Borrow-in: a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Separately a=8'hFF, b=8'hFF, bin=0 -> diff=0, bout=0.
- Start while busy: start a=10, b=3, then at edge 3 pulse start with a=200, b=1 -> result diff=7, bout=0. Exactly one done pulse, and the second request is not executed.
- Reset mid-op: start a=50, b=20, assert rst at edge 4 -> busy=0, done=0, diff=0, bout=0 immediately (asynchronous). No done pulse after release. A new start with a=50, b=20 completes to diff=30 at the normal latency.
- Result hold and back-to-back: after a completed op, hold start low for 20 cycles -> diff and bout stable. Then issue start exactly at the first IDLE cycle after DONE (a=1, b=2) -> accepted, diff=8'hFF, bout=1. Also rerun with WIDTH=4 and a=3, b=5 -> diff=4'hE, bout=1, done at edge 4.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants for the bit-serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, with start/busy/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             br_q, br_d;
    // Only WIDTH-1 partial bits are stored; the last bit goes straight into diff.
    logic [WIDTH-2:0] d_sh_q, d_sh_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic             fs_d, fs_bo;
    logic [WIDTH-1:0] d_cat;

    full_subtractor u_fs (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .bi (br_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        br_d    = br_q;
        d_sh_d  = d_sh_q;
        count_d = count_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        d_cat   = {fs_d, d_sh_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                br_d    = fs_bo;
                d_sh_d  = d_cat[WIDTH-1:1];
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                count_d = count_q + ONE;
                if (count_q == LAST) begin
                    diff_d  = d_cat;
                    bout_d  = fs_bo;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            d_sh_q  <= '0;
            count_q <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            d_sh_q  <= d_sh_d;
            count_q <= count_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 8 and 4)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start, bin, busy, done, bout;
    logic [W-1:0] a, b, diff;
    logic         start4, bin4, busy4, done4, bout4;
    logic [3:0]   a4, b4, diff4;

    int total  = 0;
    int passed = 0;
    logic [W-1:0] last_d;
    logic         last_b;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Edge 0 is the posedge after the inputs were driven; the caller drives them.
    task automatic collect(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                           input int inject, input string tag);
        logic [31:0] full;
        logic [W-1:0] exp_d;
        logic exp_b;
        int lat, busy_n, done_n;
        full   = 32'(ta) - 32'(tb) - 32'(tbin);
        exp_d  = full[W-1:0];
        exp_b  = (int'(ta) < int'(tb) + int'(tbin));
        lat    = -1;
        done_n = 0;
        @(posedge clk); #1;
        busy_n = int'(busy);
        for (int e = 1; e <= W + 1; e++) begin
            @(negedge clk);
            start = (e == inject);
            if (e == inject) begin
                a = 8'd200; b = 8'd1; bin = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = e;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), W);
        check({tag, "_busy_cycles"}, 32'(busy_n), W);
        check({tag, "_done_pulses"}, 32'(done_n), 1);
        check({tag, "_diff"}, 32'(diff), 32'(exp_d));
        check({tag, "_bout"}, 32'(bout), 32'(exp_b));
        last_d = exp_d;
        last_b = exp_b;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input int inject, input string tag);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        collect(ta, tb, tbin, inject, tag);
    endtask

    task automatic idle(input int n, input logic [W-1:0] exp_d, input logic exp_b, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            if (busy || done || diff !== exp_d || bout !== exp_b) bad++;
        end
        check({tag, "_stable"}, 32'(bad), 0);
    endtask

    initial begin
        int lat4;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        last_d = '0; last_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_diff", 32'(diff), 0);
        check("reset_bout", 32'(bout), 0);
        check("reset_busy4", 32'(busy4), 0);
        check("reset_diff4", 32'(diff4), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 1'b0, -1, "basic");
        check("basic_value", 32'(diff), 63);
        run_op(8'd5, 8'd9, 1'b0, -1, "underflow");
        run_op(8'd0, 8'd0, 1'b1, -1, "borrow_in");
        run_op(8'hFF, 8'hFF, 1'b0, -1, "equal_ff");

        run_op(8'd10, 8'd3, 1'b0, 3, "start_while_busy");
        idle(8, 8'd7, 1'b0, "no_second_op");

        // Asynchronous abort part-way through SHIFT, between clock edges.
        @(negedge clk);
        start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_diff", 32'(diff), 0);
        check("abort_bout", 32'(bout), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(12, 8'd0, 1'b0, "post_abort");

        // Release reset on the same edge start is raised.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
        collect(8'd50, 8'd20, 1'b0, -1, "after_reset");

        run_op(8'd1, 8'd2, 1'b0, -1, "back_to_back");
        idle(20, last_d, last_b, "hold");

        for (int k = 0; k < 8; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), -1, "random");
        end

        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; bin4 = 1'b0;
        @(posedge clk); #1;
        lat4 = -1;
        @(negedge clk);
        start4 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (done4 && lat4 < 0) lat4 = e;
        end
        check("w4_latency", 32'(lat4), 4);
        check("w4_diff", 32'(diff4), 32'h0E);
        check("w4_bout", 32'(bout4), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
